// File: rtl/ta_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ta_sync_pkg
//  Description : Shared types and defaults for the capture-sync responder.
//                Holds the handshake state enumeration, the default burst,
//                settle and timeout constants, and the width helper used to
//                size the cap_len status port.
//  Revision    : 1.0 - initial release
// ============================================================================
package ta_sync_pkg;

    // Handshake states of the responder
    typedef enum logic [2:0] {
        S_INIT  = 3'd0,   // post-reset settle, syncr_rdy held low
        S_READY = 3'd1,   // idle, waiting for sync_trig
        S_ACK   = 3'd2,   // trigger acknowledged, waiting for sync_trig to drop
        S_CAP   = 3'd3,   // capturing samples into the buffer
        S_DONE  = 3'd4    // single-cycle completion / status publish
    } state_t;

    // Default configuration constants
    localparam int c_dw_def          = 16;
    localparam int c_aw_def          = 10;
    localparam int c_cap_len_def     = 1024;
    localparam int c_init_cyc_def    = 16;
    localparam int c_timeout_cyc_def = 4096;

    // cap_len must hold the value CAP_LEN itself, which can be 2**AW,
    // so it needs one bit more than the buffer address.
    function automatic int cap_len_width(input int aw);
        return aw + 1;
    endfunction

endpackage : ta_sync_pkg
`default_nettype wire

// File: rtl/ta_cap_writer.sv
`default_nettype none
// ============================================================================
//  Module      : ta_cap_writer
//  Description : Capture datapath of the sync responder. Turns accepted
//                samples into buffer RAM writes with a fixed one-cycle
//                latency, counts written samples (saturating at CAP_LEN)
//                and tracks consecutive idle cycles for the abort timeout.
//
//  Ports       : clk50     in  system clock
//                rst       in  synchronous active-high reset
//                enable    in  capture window open (samples accepted)
//                clear     in  restart counters for a new burst
//                din_valid in  sample strobe
//                din       in  sample data [DW]
//                mem_we    out buffer write enable (registered)
//                mem_addr  out buffer write address [AW] (registered)
//                mem_wdata out buffer write data [DW] (registered)
//                full      out this cycle's accepted sample is the last one
//                timeout   out this idle cycle exceeds the idle allowance
//                count     out samples accepted so far in this burst [AW+1]
//  Revision    : 1.0 - initial release
// ============================================================================
module ta_cap_writer
    import ta_sync_pkg::*;
#(
    parameter int DW          = c_dw_def,
    parameter int AW          = c_aw_def,
    parameter int CAP_LEN     = c_cap_len_def,
    parameter int TIMEOUT_CYC = c_timeout_cyc_def
) (
    input  logic          clk50,
    input  logic          rst,
    input  logic          enable,
    input  logic          clear,
    input  logic          din_valid,
    input  logic [DW-1:0] din,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          full,
    output logic          timeout,
    output logic [AW:0]   count
);

    // Idle counter must be able to hold TIMEOUT_CYC itself
    localparam int c_to_w       = $clog2(TIMEOUT_CYC + 1);
    localparam int c_last_i     = CAP_LEN - 1;

    localparam logic [AW:0]       c_cap_len  = CAP_LEN[AW:0];
    localparam logic [AW:0]       c_last_idx = c_last_i[AW:0];
    localparam logic [c_to_w-1:0] c_to_lim   = TIMEOUT_CYC[c_to_w-1:0];

    logic [AW:0]       r_count;
    logic [c_to_w-1:0] r_to;
    logic              r_we;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_wdata;

    logic              w_room;
    logic              w_accept;

    // Saturation guard: once CAP_LEN samples are in, nothing else is taken
    // even if enable were to linger, so the address can never wrap.
    assign w_room   = (r_count != c_cap_len);
    assign w_accept = enable && din_valid && w_room;

    // The FSM must leave capture on the same edge that accepts the final
    // sample, so that the last write lands in the done cycle; hence these
    // are combinational look-ahead flags rather than registered state.
    assign full     = w_accept && (r_count == c_last_idx);

    // The counter is allowed to sit at TIMEOUT_CYC; the abort fires only on
    // a further idle cycle, so a sample arriving on that cycle still wins.
    assign timeout  = enable && !din_valid && (r_to == c_to_lim);

    // Sample / idle counters
    always_ff @(posedge clk50) begin
        if (rst || clear) begin
            r_count <= '0;
            r_to    <= '0;
        end else if (enable) begin
            if (w_accept) begin
                r_count <= r_count + 1'b1;
                r_to    <= '0;
            end else if (!din_valid && (r_to != c_to_lim)) begin
                r_to    <= r_to + 1'b1;
            end
        end
    end

    // Write port registers: exactly one cycle of latency per accepted sample.
    // Address/data hold their last value between writes.
    always_ff @(posedge clk50) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_accept;
            if (w_accept) begin
                r_addr  <= r_count[AW-1:0];
                r_wdata <= din;
            end
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign count     = r_count;

endmodule : ta_cap_writer
`default_nettype wire

// File: rtl/ta_sync_rsp.sv
`default_nettype none
// ============================================================================
//  Module      : ta_sync_rsp
//  Description : Responder end of the capture sync handshake. On a level
//                sync_trig it drops syncr_rdy, waits for the trigger to be
//                released, captures a burst of CAP_LEN samples into the
//                buffer RAM (aborting after TIMEOUT_CYC idle cycles), pulses
//                cap_done with the burst length and re-raises syncr_rdy.
//
//  Ports       : clk50     in  system clock, 50 MHz
//                rst       in  synchronous active-high reset
//                sync_trig in  trigger request (level)
//                syncr_rdy out 1 = idle/ready, 0 = busy
//                din_valid in  sample strobe
//                din       in  sample data [DW]
//                mem_we    out buffer write enable
//                mem_addr  out buffer write address [AW]
//                mem_wdata out buffer write data [DW]
//                cap_done  out one-cycle end-of-burst pulse
//                cap_len   out samples written in last burst [AW+1]
//                cap_err   out sticky: last burst ended by timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module ta_sync_rsp
    import ta_sync_pkg::*;
#(
    parameter int DW          = c_dw_def,
    parameter int AW          = c_aw_def,
    parameter int CAP_LEN     = c_cap_len_def,
    parameter int INIT_CYC    = c_init_cyc_def,
    parameter int TIMEOUT_CYC = c_timeout_cyc_def
) (
    input  logic                         clk50,
    input  logic                         rst,
    input  logic                         sync_trig,
    output logic                         syncr_rdy,
    input  logic                         din_valid,
    input  logic [DW-1:0]                din,
    output logic                         mem_we,
    output logic [AW-1:0]                mem_addr,
    output logic [DW-1:0]                mem_wdata,
    output logic                         cap_done,
    output logic [cap_len_width(AW)-1:0] cap_len,
    output logic                         cap_err
);

    localparam int c_set_w      = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
    localparam int c_set_last_i = INIT_CYC - 1;
    localparam logic [c_set_w-1:0] c_set_last = c_set_last_i[c_set_w-1:0];

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_set_w-1:0] r_settle;
    logic               r_rdy;
    logic               r_cap_done;
    logic [AW:0]        r_cap_len;
    logic               r_cap_err;

    logic               w_trig_acc;
    logic               w_cap_en;
    logic               w_full;
    logic               w_timeout;
    logic [AW:0]        w_count;

    assign w_cap_en = (r_state == S_CAP);

    // ------------------------------------------------------------------
    // Capture datapath
    // ------------------------------------------------------------------
    ta_cap_writer #(
        .DW          (DW),
        .AW          (AW),
        .CAP_LEN     (CAP_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_cap_writer (
        .clk50     (clk50),
        .rst       (rst),
        .enable    (w_cap_en),
        .clear     (w_trig_acc),
        .din_valid (din_valid),
        .din       (din),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .full      (w_full),
        .timeout   (w_timeout),
        .count     (w_count)
    );

    // ------------------------------------------------------------------
    // Handshake FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_trig_acc  = 1'b0;
        case (r_state)
            S_INIT: begin
                if (r_settle == c_set_last) begin
                    w_state_nxt = S_READY;
                end
            end
            S_READY: begin
                // Level-sensitive: a trigger still high on entry is taken
                // immediately as a fresh request.
                if (sync_trig) begin
                    w_state_nxt = S_ACK;
                    w_trig_acc  = 1'b1;
                end
            end
            S_ACK: begin
                // No timeout here: the initiator owns the release.
                if (!sync_trig) begin
                    w_state_nxt = S_CAP;
                end
            end
            S_CAP: begin
                if (w_full || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_READY;
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake FSM: state and status registers
    // Outputs are registered from the next state so they line up exactly
    // with the state they describe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk50) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_settle   <= '0;
            r_rdy      <= 1'b0;
            r_cap_done <= 1'b0;
            r_cap_len  <= '0;
            r_cap_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rdy      <= (w_state_nxt == S_READY);
            r_cap_done <= (w_state_nxt == S_DONE);

            if ((r_state == S_INIT) && (r_settle != c_set_last)) begin
                r_settle <= r_settle + 1'b1;
            end

            // The writer's count lags the final accepted sample by one
            // edge, so add it in here to publish the length in S_DONE.
            if (w_cap_en && (w_full || w_timeout)) begin
                r_cap_len <= w_full ? (w_count + 1'b1) : w_count;
            end

            if (w_trig_acc) begin
                r_cap_err <= 1'b0;
            end else if (w_timeout) begin
                r_cap_err <= 1'b1;
            end
        end
    end

    assign syncr_rdy = r_rdy;
    assign cap_done  = r_cap_done;
    assign cap_len   = r_cap_len;
    assign cap_err   = r_cap_err;

endmodule : ta_sync_rsp
`default_nettype wire

// File: tb/tb_ta_sync_rsp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ta_sync_rsp
//  Description : Self-checking bench for ta_sync_rsp. Drives directed and
//                randomised handshake bursts and compares every cycle of
//                the DUT outputs against expectations derived from the
//                burst rules (sample count, idle-run length, trigger level).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ta_sync_rsp;

    localparam int DW          = 16;
    localparam int AW          = 10;
    localparam int CAP_LEN     = 8;
    localparam int INIT_CYC    = 16;
    localparam int TIMEOUT_CYC = 20;

    logic          clk50 = 1'b0;
    logic          rst;
    logic          sync_trig;
    logic          syncr_rdy;
    logic          din_valid;
    logic [DW-1:0] din;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          cap_done;
    logic [AW:0]   cap_len;
    logic          cap_err;

    int checks   = 0;
    int failures = 0;
    int last_len = 0;

    always #10 clk50 = ~clk50;

    ta_sync_rsp #(
        .DW          (DW),
        .AW          (AW),
        .CAP_LEN     (CAP_LEN),
        .INIT_CYC    (INIT_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk50     (clk50),
        .rst       (rst),
        .sync_trig (sync_trig),
        .syncr_rdy (syncr_rdy),
        .din_valid (din_valid),
        .din       (din),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cap_done  (cap_done),
        .cap_len   (cap_len),
        .cap_err   (cap_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy"},   32'(syncr_rdy), 32'd0);
        chk({tag, "_we"},    32'(mem_we),    32'd0);
        chk({tag, "_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_done"},  32'(cap_done),  32'd0);
        chk({tag, "_len"},   32'(cap_len),   32'd0);
        chk({tag, "_err"},   32'(cap_err),   32'd0);
    endtask

    // Reset, then expect syncr_rdy low for INIT_CYC cycles and high after.
    task automatic reset_and_settle();
        rst       = 1'b1;
        sync_trig = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        tick();
        chk_all_zero("reset");
        tick();
        rst = 1'b0;
        for (int n = 1; n <= INIT_CYC; n++) begin
            tick();
            chk("settle_rdy",  32'(syncr_rdy), 32'(n == INIT_CYC));
            chk("settle_we",   32'(mem_we),    32'd0);
            chk("settle_done", 32'(cap_done),  32'd0);
            chk("settle_err",  32'(cap_err),   32'd0);
        end
        last_len = 0;
    endtask

    // Raise the trigger for 'hold' cycles from READY, then release it.
    // Samples offered while the trigger is high or on the release cycle
    // must be ignored.
    task automatic trig_phase(input int hold);
        chk("pre_trig_rdy", 32'(syncr_rdy), 32'd1);
        sync_trig = 1'b1;
        for (int i = 0; i < hold; i++) begin
            din_valid = 1'($urandom_range(1, 0));
            din       = 16'($urandom);
            tick();
            chk("ack_rdy", 32'(syncr_rdy), 32'd0);
            chk("ack_we",  32'(mem_we),    32'd0);
            if (i == 0) chk("ack_err_clr", 32'(cap_err), 32'd0);
        end
        sync_trig = 1'b0;
        din_valid = 1'b1;
        din       = 16'($urandom);
        tick();
        chk("rel_we",  32'(mem_we),    32'd0);
        chk("rel_rdy", 32'(syncr_rdy), 32'd0);
    endtask

    // Capture phase with its own reference: a sample is written one cycle
    // after it is offered; the burst ends at CAP_LEN samples or on an idle
    // cycle that follows TIMEOUT_CYC consecutive idle cycles.
    task automatic cap_phase(input int gap_min, input int gap_max, input int stall_after,
                             input bit retrig, input int abort_at, input int base,
                             output bit timed);
        int k    = 0;
        int idle = 0;
        int gap  = 0;
        bit v;
        bit end_full;
        bit end_to;
        logic [DW-1:0] d;
        timed = 1'b0;
        for (int iter = 0; iter < 2000; iter++) begin
            if (stall_after >= 0 && k >= stall_after) begin
                v = 1'b0;
            end else if (gap > 0) begin
                v = 1'b0;
                gap--;
            end else begin
                v = 1'b1;
            end
            d = (base >= 0) ? 16'(base + k) : 16'($urandom);
            if (retrig && k >= 1) sync_trig = 1'b1;
            din_valid = v;
            din       = d;
            end_full  = 1'b0;
            end_to    = 1'b0;
            if (v) begin
                k++;
                idle = 0;
                if (k == CAP_LEN) end_full = 1'b1;
                gap = $urandom_range(gap_max, gap_min);
            end else if (idle == TIMEOUT_CYC) begin
                end_to = 1'b1;
            end else begin
                idle++;
            end
            tick();
            chk("cap_we", 32'(mem_we), 32'(v));
            if (v) begin
                chk("cap_addr",  32'(mem_addr),  32'(k - 1));
                chk("cap_wdata", 32'(mem_wdata), 32'(d));
            end
            if (end_full || end_to) begin
                chk("done_pulse", 32'(cap_done),  32'd1);
                chk("done_len",   32'(cap_len),   32'(k));
                chk("done_err",   32'(cap_err),   32'(end_to));
                chk("done_rdy",   32'(syncr_rdy), 32'd0);
                timed    = end_to;
                last_len = k;
                din_valid = 1'b0;
                return;
            end
            chk("cap_done_low", 32'(cap_done),  32'd0);
            chk("cap_rdy_low",  32'(syncr_rdy), 32'd0);
            if (abort_at > 0 && v && k == abort_at) begin
                din_valid = 1'b0;
                return;
            end
        end
        chk("cap_budget", 32'd1, 32'd0);
    endtask

    // Cycle after S_DONE: ready again with status held. With retrig the
    // trigger is still high, so it must be accepted straight away.
    task automatic after_done(input bit retrig, input bit timed);
        din_valid = 1'b0;
        tick();
        chk("post_rdy",  32'(syncr_rdy), 32'd1);
        chk("post_done", 32'(cap_done),  32'd0);
        chk("post_err",  32'(cap_err),   32'(timed));
        chk("post_len",  32'(cap_len),   32'(last_len));
        chk("post_we",   32'(mem_we),    32'd0);
        if (retrig) begin
            tick();
            chk("retrig_rdy", 32'(syncr_rdy), 32'd0);
            chk("retrig_err", 32'(cap_err),   32'd0);
            sync_trig = 1'b0;
            din_valid = 1'b1;
            tick();
            chk("retrig_rel_we", 32'(mem_we), 32'd0);
        end
    endtask

    initial begin
        bit timed;
        rst       = 1'b1;
        sync_trig = 1'b0;
        din_valid = 1'b0;
        din       = '0;

        reset_and_settle();

        // Directed: 3-cycle trigger, continuous data 0x100..0x107
        trig_phase(3);
        cap_phase(0, 0, -1, 1'b0, 0, 'h100, timed);
        chk("dir_timed", 32'(timed), 32'd0);
        after_done(1'b0, timed);

        // Timeout: 3 samples then stall
        trig_phase(1);
        cap_phase(0, 0, 3, 1'b0, 0, -1, timed);
        chk("to_timed", 32'(timed), 32'd1);
        after_done(1'b0, timed);

        // Gaps exactly at the idle allowance: sample must win every time
        trig_phase(2);
        cap_phase(TIMEOUT_CYC, TIMEOUT_CYC, -1, 1'b0, 0, -1, timed);
        chk("gap_timed", 32'(timed), 32'd0);
        after_done(1'b0, timed);

        // Timeout burst with trigger re-raised during capture and held
        trig_phase(2);
        cap_phase(0, 0, 2, 1'b1, 0, -1, timed);
        after_done(1'b1, timed);
        cap_phase(0, 3, -1, 1'b0, 0, -1, timed);
        after_done(1'b0, timed);

        // Reset after the 4th write, then a clean burst from address 0
        trig_phase(1);
        cap_phase(0, 0, -1, 1'b0, 4, -1, timed);
        reset_and_settle();
        trig_phase(2);
        cap_phase(0, 2, -1, 1'b0, 0, -1, timed);
        after_done(1'b0, timed);

        // Randomised bursts
        for (int r = 0; r < 6; r++) begin
            int hold;
            int stall;
            hold  = $urandom_range(4, 1);
            stall = ($urandom_range(1, 0) == 1) ? $urandom_range(CAP_LEN - 1, 0) : -1;
            trig_phase(hold);
            cap_phase(0, 5, stall, 1'b0, 0, -1, timed);
            after_done(1'b0, timed);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ta_sync_rsp
`default_nettype wire

// File: doc/ta_sync_rsp.md
Name: ta_sync_rsp

Overview:
- Responder end of the capture sync handshake; the capture-side controller is the initiator.
- The initiator raises sync_trig. This block answers by dropping syncr_rdy, captures a burst of CAP_LEN samples into buffer memory, then re-raises syncr_rdy.
- The initiator treats the re-raised syncr_rdy as "capture complete" and then starts its memory-reset sequence.
- Sits between the ADC sample stream and the capture buffer RAM write port, all in the clk50 domain.

Parameters:
- DW, 16, sample data width.
- AW, 10, buffer address width.
- CAP_LEN, 1024, samples per burst; legal range 1..2**AW.
- INIT_CYC, 16, settle cycles after reset before the first syncr_rdy assertion; legal range >= 1.
- TIMEOUT_CYC, 4096, maximum cycles without din_valid during capture before the burst is aborted.

Ports:
- clk50  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- sync_trig  in  1  trigger request from the initiator; level, held until syncr_rdy falls.
- syncr_rdy  out  1  1 = idle/ready; 0 = busy, trigger acknowledged.
- din_valid  in  1  sample strobe.
- din  in  DW  sample data.
- mem_we  out  1  buffer write enable.
- mem_addr  out  AW  buffer write address.
- mem_wdata  out  DW  buffer write data.
- cap_done  out  1  one-cycle pulse at the end of a burst (normal or aborted).
- cap_len  out  AW+1  samples written in the last burst; valid from the cap_done cycle until the next trigger.
- cap_err  out  1  sticky: last burst ended by timeout; cleared on the next accepted trigger.

Behaviour:
- Reset values, all registered: syncr_rdy=0, mem_we=0, mem_addr=0, mem_wdata=0, cap_done=0, cap_len=0, cap_err=0, state=S_INIT, all counters 0.
- S_INIT:
  - syncr_rdy=0; settle counter increments.
  - After INIT_CYC cycles go to S_READY; syncr_rdy=1 on the first S_READY cycle.
- S_READY:
  - syncr_rdy=1.
  - sync_trig=1 sampled: next cycle syncr_rdy=0, cap_err=0, write counter=0, timeout counter=0; go to S_ACK.
  - sync_trig is level-sensitive. If it is already high on S_READY entry, it is taken as a new trigger immediately.
- S_ACK:
  - syncr_rdy=0; wait for sync_trig=0, then go to S_CAP.
  - din_valid is ignored in S_ACK and no writes occur.
  - The state is held indefinitely if sync_trig stays high; there is no timeout in S_ACK.
- S_CAP:
  - Each cycle with din_valid=1: next cycle mem_we=1, mem_addr=write count, mem_wdata=din. Write count increments; timeout counter clears.
  - Write latency is exactly 1 cycle; mem_we is 0 on any cycle not preceded by an accepted sample.
  - After the CAP_LEN-th accepted sample, go to S_DONE; further din_valid is ignored.
  - Each cycle with din_valid=0: timeout counter increments. When it reaches TIMEOUT_CYC: cap_err=1, go to S_DONE.
  - If din_valid=1 on the same cycle the timeout would fire, the sample wins: it is written and the counter clears.
- S_DONE:
  - One cycle. cap_done=1, cap_len=write count, syncr_rdy=0.
  - The last mem_we pulse lands in this cycle.
  - Next state S_READY; syncr_rdy returns to 1 the following cycle.
- Address never wraps: write count saturates at CAP_LEN; mem_addr max = CAP_LEN-1.
- rst mid-burst:
  - Abort immediately and return to S_INIT with reset values; partial data in RAM is left as is.
  - The initiator sees syncr_rdy=0 until INIT_CYC expires.
- sync_trig is ignored outside S_READY and S_ACK.

Decomposition:
- Shared package ta_sync_pkg holds:
  - state enum {S_INIT, S_READY, S_ACK, S_CAP, S_DONE};
  - default constants for CAP_LEN, INIT_CYC, TIMEOUT_CYC;
  - width helper for the cap_len width.
- One natural sub-module, ta_cap_writer:
  - contains the write counter, mem_we/mem_addr/mem_wdata registers, the saturate-at-CAP_LEN compare and the timeout counter;
  - inputs: enable, clear, din_valid, din;
  - outputs: full, timeout, count.
- The top level keeps the handshake FSM and the status registers.

Test Plan:
- Reset release, INIT_CYC=16 -> syncr_rdy=0 for cycles 1..16, =1 on cycle 17; all other outputs 0 throughout.
- Trigger: sync_trig high 3 cycles, din_valid continuous, CAP_LEN=8, data 0x100..0x107:
  - syncr_rdy falls 1 cycle after trigger; writes start only after sync_trig falls;
  - mem_addr 0..7 carry 0x100..0x107;
  - cap_done pulses once with cap_len=8, cap_err=0; syncr_rdy=1 the next cycle.
- Timeout: CAP_LEN=8, TIMEOUT_CYC=20, 3 samples then din_valid stuck 0 -> after 20 idle cycles cap_done=1, cap_len=3, cap_err=1, syncr_rdy returns high.
- Gappy input: din_valid asserted every 5th cycle with TIMEOUT_CYC=4 -> no timeout; full 8 samples written with correct addresses.
- rst asserted after the 4th write of 8 -> all outputs reset next cycle; syncr_rdy reasserts INIT_CYC cycles after rst drops; next trigger writes from addr 0 and clears cap_err.
- sync_trig held high across S_DONE into S_READY -> treated as a new trigger in the first S_READY cycle; cap_err from the previous timeout burst is cleared.
